// File: rtl/riscv_pkg.sv
// Shared types for the load/store sequencer.
//   lsu_size_e  : funct3 size/sign codes for loads and stores
//   lsu_state_e : sequencer states
//   lsu_req_t   : request as latched from the memory stage
//   LOAD/STORE  : major opcodes, used to tag the latched request
// Helpers classify funct3/address pairs as illegal or misaligned and
// produce the forced-aligned address.
package riscv_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  function automatic logic is_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // funct3[1:0] carries the size for both signed and unsigned codes.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

  function automatic logic [31:0] force_align(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'b01:   return {a[31:1], 1'b0};
      2'b10:   return {a[31:2], 2'b00};
      default: return a;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane datapath for the load/store sequencer (purely combinational).
//   funct3     : size/sign code
//   addr_lo    : byte offset within the word
//   wdata      : raw store data (rs2)
//   rdata      : raw load word from memory
//   bmask      : byte enables
//   wdata_lane : store data replicated into every lane it may land in
//   rdata_ext  : selected and sign/zero-extended load data
// Lane layout assumes a 32-bit word of four bytes (halfword = two lanes).
module lsu_lane
  import riscv_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int VEC_W     = 8
) (
  input  logic [2:0]                   funct3,
  input  logic [$clog2(NUM_LANES)-1:0] addr_lo,
  input  logic [NUM_LANES*VEC_W-1:0]   wdata,
  input  logic [NUM_LANES*VEC_W-1:0]   rdata,
  output logic [NUM_LANES-1:0]         bmask,
  output logic [NUM_LANES*VEC_W-1:0]   wdata_lane,
  output logic [NUM_LANES*VEC_W-1:0]   rdata_ext
);
  localparam int W = NUM_LANES * VEC_W;

  logic [NUM_LANES-1:0][VEC_W-1:0] wd_in, wd_out, rd_in;
  logic [VEC_W-1:0]                rb;
  logic [2*VEC_W-1:0]              rh;

  assign wd_in      = wdata;
  assign rd_in      = rdata;
  assign wdata_lane = wd_out;

  // Replicate so the memory picks the right lane purely via bmask.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    always_comb begin
      case (funct3[1:0])
        2'b00:   wd_out[g] = wd_in[0];
        2'b01:   wd_out[g] = wd_in[g % 2];
        default: wd_out[g] = wd_in[g];
      endcase
    end
  end

  always_comb begin
    case (funct3[1:0])
      2'b00:   bmask = NUM_LANES'(1) << addr_lo;
      2'b01:   bmask = NUM_LANES'(3) << {addr_lo[1], 1'b0};
      default: bmask = '1;
    endcase
  end

  assign rb = rd_in[addr_lo];
  assign rh = addr_lo[1] ? rdata[W-1:W/2] : rdata[W/2-1:0];

  always_comb begin
    case (funct3)
      SZ_B:    rdata_ext = {{(W-VEC_W){rb[VEC_W-1]}}, rb};
      SZ_H:    rdata_ext = {{(W-2*VEC_W){rh[2*VEC_W-1]}}, rh};
      SZ_BU:   rdata_ext = {{(W-VEC_W){1'b0}}, rb};
      SZ_HU:   rdata_ext = {{(W-2*VEC_W){1'b0}}, rh};
      SZ_W:    rdata_ext = rdata;
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu_seq.sv
// Multi-cycle load/store sequencer between the memory stage and a
// variable-latency data memory (req/ack handshake).
//   i_req_*/i_funct3/i_addr/i_wdata : access from the memory stage
//   o_stall                         : hold the pipeline
//   o_done/o_err/o_rdata            : one-cycle completion, error, load result
//   o_mem_*                         : request to memory, stable while in REQ
//   i_mem_ack/i_mem_rdata           : memory response
// Build option LSU_MISALIGN_TRAP_EN: misaligned accesses end in an error
// without touching memory; otherwise they are forced aligned and proceed.
module lsu_seq
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_vld,
  input  logic        i_req_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  lsu_state_e  state;
  lsu_req_t    req_q;
  logic [7:0]  cnt;
  logic        trap;
  logic [31:0] addr_l;
  logic [3:0]  ln_bmask;
  logic [31:0] ln_wdata, ln_rdata;
  logic        active, is_st;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap   = is_illegal(i_funct3) || is_misaligned(i_funct3, i_addr[1:0]);
  assign addr_l = i_addr;
`else
  assign trap   = is_illegal(i_funct3);
  assign addr_l = force_align(i_funct3, i_addr);
`endif

  lsu_lane u_lane (
    .funct3     (req_q.funct3),
    .addr_lo    (req_q.addr[1:0]),
    .wdata      (req_q.wdata),
    .rdata      (i_mem_rdata),
    .bmask      (ln_bmask),
    .wdata_lane (ln_wdata),
    .rdata_ext  (ln_rdata)
  );

  assign active      = (state == REQ);
  assign is_st       = (req_q.op == STORE);
  assign o_stall     = ((state == IDLE) && i_req_vld) || active;
  assign o_mem_req   = active;
  assign o_mem_we    = active && is_st;
  assign o_mem_addr  = active ? {req_q.addr[31:2], 2'b00} : '0;
  assign o_mem_wdata = (active && is_st) ? ln_wdata : '0;
  assign o_mem_bmask = active ? ln_bmask : '0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      req_q   <= '0;
      cnt     <= '0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
      o_rdata <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        IDLE: if (i_req_vld) begin
          req_q <= '{op: i_req_we ? STORE : LOAD, funct3: i_funct3,
                     addr: addr_l, wdata: i_wdata};
          if (trap) begin
            state   <= DONE;
            o_done  <= 1'b1;
            o_err   <= 1'b1;
            o_rdata <= '0;
          end else begin
            state <= REQ;
            cnt   <= '0;
          end
        end
        REQ: begin
          if (cnt != 8'hFF) cnt <= cnt + 8'd1;
          // ack takes priority over an expiring timeout
          if (i_mem_ack) begin
            state   <= DONE;
            o_done  <= 1'b1;
            o_rdata <= is_st ? '0 : ln_rdata;
          end else if (cnt == TO_LAST) begin
            state   <= DONE;
            o_done  <= 1'b1;
            o_err   <= 1'b1;
            o_rdata <= '0;
          end
        end
        DONE: begin
          state   <= IDLE;
          o_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_seq.sv
module tb_lsu_seq;
  logic        i_clk = 1'b0, i_reset = 1'b1;
  logic        i_req_vld = 1'b0, i_req_we = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_addr = '0, i_wdata = '0;
  logic        o_stall, o_done, o_err;
  logic [31:0] o_rdata;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = '0;

  int n_chk = 0, n_fail = 0;

  always #5 i_clk = ~i_clk;

  lsu_seq #(.TIMEOUT(16)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req_vld(i_req_vld), .i_req_we(i_req_we),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_stall(o_stall), .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge i_clk);
    #1;
  endtask

  // One transaction: request in the first cycle, ack on REQ cycle ack_at
  // (0 = never). Reports the REQ-cycle memory outputs and completion values.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input int ack_at,
                      output logic [31:0] maddr, output logic [31:0] mwdata,
                      output logic [3:0] bm, output logic mwe, output logic [31:0] rdata,
                      output logic err, output logic st0, output logic st_req,
                      output logic st_done, output int req_cycles, output int lat);
    logic fin;
    fin = 1'b0; maddr = '0; mwdata = '0; bm = '0; mwe = 1'b0; rdata = '1; err = 1'b1;
    st_req = 1'b1; st_done = 1'b1; req_cycles = 0; lat = 0;
    cyc;
    i_req_vld = 1'b1; i_req_we = we; i_funct3 = f3; i_addr = a; i_wdata = wd;
    #1;
    st0 = o_stall;
    while (!fin && lat < 64) begin
      cyc;
      lat++;
      i_req_vld = 1'b0;
      i_mem_ack = 1'b0;
      #1;
      if (o_done) begin
        fin = 1'b1; rdata = o_rdata; err = o_err; st_done = o_stall;
      end else if (o_mem_req) begin
        req_cycles++;
        maddr = o_mem_addr; mwdata = o_mem_wdata; bm = o_mem_bmask; mwe = o_mem_we;
        st_req = st_req & o_stall;
        if (req_cycles == ack_at) begin
          i_mem_ack = 1'b1;
          i_mem_rdata = rd;
        end
      end
    end
    i_mem_ack = 1'b0;
  endtask

  logic [31:0] ma, mw, rdo;
  logic [3:0]  bm;
  logic        mwe, er, s0, sr, sd, seen;
  int          rc, lt;

  initial begin
    // reset state
    #12;
    chkb("rst_mem_req", o_mem_req, 1'b0);
    chkb("rst_done", o_done, 1'b0);
    chkb("rst_err", o_err, 1'b0);
    chkb("rst_stall", o_stall, 1'b0);
    chk("rst_rdata", o_rdata, 32'h0);
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    chk("rst_bmask", 32'(o_mem_bmask), 32'h0);
    i_reset = 1'b0;

    // SW, ack on first REQ cycle: 2-cycle stall
    xact(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1, ma, mw, bm, mwe, rdo, er, s0, sr, sd, rc, lt);
    chk("sw_addr", ma, 32'h100);
    chk("sw_bmask", 32'(bm), 32'hF);
    chk("sw_wdata", mw, 32'hDEADBEEF);
    chkb("sw_we", mwe, 1'b1);
    chkb("sw_err", er, 1'b0);
    chk("sw_lat", 32'(lt), 32'd2);
    chkb("sw_stall0", s0, 1'b1);
    chkb("sw_stall1", sr, 1'b1);
    chkb("sw_stall_done", sd, 1'b0);

    // LB 0x203, ack on third REQ cycle
    xact(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF1234, 3, ma, mw, bm, mwe, rdo, er, s0, sr, sd, rc, lt);
    chk("lb_bmask", 32'(bm), 32'h8);
    chk("lb_addr", ma, 32'h200);
    chk("lb_wdata", mw, 32'h0);
    chkb("lb_we", mwe, 1'b0);
    chk("lb_rdata", rdo, 32'hFFFFFF80);
    chk("lb_reqcyc", 32'(rc), 32'd3);
    chk("lb_lat", 32'(lt), 32'd4);
    xact(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF1234, 1, ma, mw, bm, mwe, rdo, er, s0, sr, sd, rc, lt);
    chk("lbu_rdata", rdo, 32'h00000080);

    // halfword / byte lanes
    xact(1'b1, 3'b001, 32'h12, 32'h0000ABCD, 32'h0, 1, ma, mw, bm, mwe, rdo, er, s0, sr, sd, rc, lt);
    chk("sh_bmask", 32'(bm), 32'hC);
    chk("sh_wdata", mw, 32'hABCDABCD);
    chk("sh_addr", ma, 32'h10);
    xact(1'b0, 3'b101, 32'h12, 32'h0, 32'hBEEF0000, 1, ma, mw, bm, mwe, rdo, er, s0, sr, sd, rc, lt);
    chk("lhu_rdata", rdo, 32'h0000BEEF);
    xact(1'b0, 3'b001, 32'h10, 32'h0, 32'h00008001, 2, ma, mw, bm, mwe, rdo, er, s0, sr, sd, rc, lt);
    chk("lh_bmask", 32'(bm), 32'h3);
    chk("lh_rdata", rdo, 32'hFFFF8001);
    xact(1'b1, 3'b000, 32'h1, 32'h1234565A, 32'h0, 1, ma, mw, bm, mwe, rdo, er, s0, sr, sd, rc, lt);
    chk("sb_bmask", 32'(bm), 32'h2);
    chk("sb_wdata", mw, 32'h5A5A5A5A);
    xact(1'b0, 3'b010, 32'h104, 32'h0, 32'h89ABCDEF, 1, ma, mw, bm, mwe, rdo, er, s0, sr, sd, rc, lt);
    chk("lw_rdata", rdo, 32'h89ABCDEF);

    // timeout: no ack
    xact(1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 0, ma, mw, bm, mwe, rdo, er, s0, sr, sd, rc, lt);
    chkb("to_err", er, 1'b1);
    chk("to_rdata", rdo, 32'h0);
    chk("to_reqcyc", 32'(rc), 32'd16);
    chk("to_lat", 32'(lt), 32'd17);
    cyc; #1;
    chkb("to_req_after", o_mem_req, 1'b0);
    chkb("to_done_after", o_done, 1'b0);

    // misaligned LW
    xact(1'b0, 3'b010, 32'h102, 32'h0, 32'h13572468, 1, ma, mw, bm, mwe, rdo, er, s0, sr, sd, rc, lt);
`ifdef LSU_MISALIGN_TRAP_EN
    chkb("mis_err", er, 1'b1);
    chk("mis_reqcyc", 32'(rc), 32'd0);
    chk("mis_lat", 32'(lt), 32'd1);
`else
    chkb("mis_err", er, 1'b0);
    chk("mis_addr", ma, 32'h100);
    chk("mis_bmask", 32'(bm), 32'hF);
    chk("mis_rdata", rdo, 32'h13572468);
`endif

    // illegal funct3: error, no memory access
    xact(1'b1, 3'b011, 32'h40, 32'h1, 32'h0, 1, ma, mw, bm, mwe, rdo, er, s0, sr, sd, rc, lt);
    chkb("ill_err", er, 1'b1);
    chk("ill_reqcyc", 32'(rc), 32'd0);
    chk("ill_lat", 32'(lt), 32'd1);

    // ack while idle is ignored
    cyc; i_mem_ack = 1'b1; #1;
    cyc; i_mem_ack = 1'b0; #1;
    chkb("idle_ack_done", o_done, 1'b0);
    chkb("idle_ack_req", o_mem_req, 1'b0);

    // request held through DONE is taken in the following IDLE cycle
    cyc; i_req_vld = 1'b1; i_req_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h20; #1;
    cyc; i_mem_ack = 1'b1; i_mem_rdata = 32'h11111111; i_addr = 32'h24; #1;
    cyc; i_mem_ack = 1'b0; #1;
    chkb("dn_done", o_done, 1'b1);
    chkb("dn_stall", o_stall, 1'b0);
    chk("dn_rdata", o_rdata, 32'h11111111);
    cyc; #1;
    chkb("dn_idle_req", o_mem_req, 1'b0);
    chkb("dn_idle_stall", o_stall, 1'b1);
    cyc; i_req_vld = 1'b0; #1;
    chk("dn_next_addr", o_mem_addr, 32'h24);
    i_mem_ack = 1'b1; i_mem_rdata = 32'h22222222;
    cyc; i_mem_ack = 1'b0; #1;
    chk("dn_next_rdata", o_rdata, 32'h22222222);

    // reset during the second REQ cycle
    cyc; i_req_vld = 1'b1; i_req_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h40; #1;
    cyc; i_req_vld = 1'b0; #1;
    chkb("rr_req1", o_mem_req, 1'b1);
    cyc; #1;
    chkb("rr_req2", o_mem_req, 1'b1);
    i_reset = 1'b1; #1;
    chkb("rr_req_drop", o_mem_req, 1'b0);
    chkb("rr_stall", o_stall, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc; #1;
      if (i == 0) i_reset = 1'b0;
      seen = seen | o_done;
    end
    chkb("rr_no_done", seen, 1'b0);
    xact(1'b1, 3'b010, 32'h80, 32'hCAFEF00D, 32'h0, 2, ma, mw, bm, mwe, rdo, er, s0, sr, sd, rc, lt);
    chk("rr_fresh_addr", ma, 32'h80);
    chk("rr_fresh_wdata", mw, 32'hCAFEF00D);
    chkb("rr_fresh_err", er, 1'b0);
    chk("rr_fresh_lat", 32'(lt), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
